// File: rtl/ram_paged_ctl.sv
// Paged nibble-lane RAM controller: valid/ready command port, page-table translation,
// per-page write protect, range fault detection and lane-masked writes to an internal array.
module ram_paged_ctl #(
    parameter int unsigned NIB_W      = 4,
    parameter int unsigned LANES      = 2,
    parameter int unsigned VA_W       = 16,
    parameter int unsigned OFFS_W     = 13,
    parameter int unsigned PAGE_SEL_W = 2,
    parameter int unsigned PPN_W      = 4,
    parameter int unsigned MEM_AW     = 14
) (
    input  logic                     ram_clk,
    input  logic                     ram_rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [VA_W-1:0]          cmd_va,
    input  logic [LANES-1:0]         cmd_lane,
    input  logic [LANES*NIB_W-1:0]   cmd_wdata,
    output logic                     rsp_valid,
    output logic [LANES*NIB_W-1:0]   rsp_data,
    output logic                     rsp_fault,
    output logic [PPN_W+OFFS_W-1:0]  pa
);
    localparam int unsigned DW        = LANES * NIB_W;
    localparam int unsigned PA_W      = PPN_W + OFFS_W;
    localparam int unsigned NPAGES    = 1 << PAGE_SEL_W;
    localparam int unsigned MEM_DEPTH = 1 << MEM_AW;
    localparam int unsigned VS_W      = OFFS_W + PAGE_SEL_W;
    localparam int unsigned PE_W      = PPN_W + 1;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_PLOAD = 2'b10;
    localparam logic [1:0] OP_PREAD = 2'b11;

    typedef enum logic [1:0] {ST_IDLE, ST_XLAT, ST_ACC, ST_RESP} state_t;
    state_t state_q, state_n;

    logic [1:0]            op_q;
    logic [VS_W-1:0]       va_q;
    logic [LANES-1:0]      lane_q;
    logic [DW-1:0]         wdata_q;
    logic [PPN_W-1:0]      ppn_q [NPAGES];
    logic [NPAGES-1:0]     wp_q;
    logic [PE_W-1:0]       pe_q;
    logic                  range_flt_q;
    logic                  wp_flt_q;
    logic [DW-1:0]         rd_q;
    logic [DW-1:0]         mem [MEM_DEPTH];

    logic [PAGE_SEL_W-1:0] idx_c;
    logic [PAGE_SEL_W-1:0] pidx_c;
    logic [PA_W-1:0]       pa_c;
    logic                  range_bad_c;
    logic                  mem_we_c;
    logic [MEM_AW-1:0]     maddr_c;

    assign idx_c     = va_q[OFFS_W +: PAGE_SEL_W];
    assign pidx_c    = va_q[PAGE_SEL_W-1:0];
    assign pa_c      = {ppn_q[idx_c], va_q[OFFS_W-1:0]};
    assign maddr_c   = pa[MEM_AW-1:0];
    assign cmd_ready = (state_q == ST_IDLE) && !ram_rst;
    assign mem_we_c  = (state_q == ST_ACC) && (op_q == OP_WRITE) &&
                       !range_flt_q && !wp_flt_q && !ram_rst;

    // Physical pages beyond the implemented array raise a range fault.
    if (MEM_AW < PA_W) begin : g_range
        assign range_bad_c = |pa_c[PA_W-1:MEM_AW];
    end else begin : g_no_range
        assign range_bad_c = 1'b0;
    end

    // VA bits above the page-select field play no part in translation.
    if (VA_W > VS_W) begin : g_va_hi
        logic unused_va_c;
        assign unused_va_c = ^cmd_va[VA_W-1:VS_W];
    end

    always_ff @(posedge ram_clk) begin
        if (ram_rst) state_q <= ST_IDLE;
        else         state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            ST_IDLE: if (cmd_valid) state_n = ST_XLAT;
            ST_XLAT: state_n = op_q[1] ? ST_RESP : ST_ACC;
            ST_ACC:  state_n = ST_RESP;
            ST_RESP: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // Command capture, translation, page table and response registers.
    always_ff @(posedge ram_clk) begin
        if (ram_rst) begin
            op_q        <= '0;
            va_q        <= '0;
            lane_q      <= '0;
            wdata_q     <= '0;
            pe_q        <= '0;
            range_flt_q <= 1'b0;
            wp_flt_q    <= 1'b0;
            wp_q        <= '0;
            pa          <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_fault   <= 1'b0;
            for (int i = 0; i < int'(NPAGES); i++) ppn_q[i] <= PPN_W'(i);
        end else begin
            rsp_valid <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q    <= cmd_op;
                        va_q    <= cmd_va[VS_W-1:0];
                        lane_q  <= cmd_lane;
                        wdata_q <= cmd_wdata;
                    end
                end
                ST_XLAT: begin
                    pa          <= pa_c;
                    range_flt_q <= range_bad_c;
                    wp_flt_q    <= (op_q == OP_WRITE) && wp_q[idx_c];
                    if (op_q == OP_PLOAD) begin
                        ppn_q[pidx_c] <= wdata_q[PPN_W-1:0];
                        wp_q[pidx_c]  <= wdata_q[PPN_W];
                    end
                    pe_q <= {wp_q[pidx_c], ppn_q[pidx_c]};
                end
                ST_RESP: begin
                    rsp_valid <= 1'b1;
                    rsp_fault <= !op_q[1] && (range_flt_q || wp_flt_q);
                    case (op_q)
                        OP_READ:  rsp_data <= range_flt_q ? '0 : rd_q;
                        OP_PREAD: rsp_data <= DW'(pe_q);
                        default:  rsp_data <= '0;
                    endcase
                end
                default: ;
            endcase
        end
    end

    // Memory array: lane-masked write and synchronous read in ACC, contents never reset.
    always_ff @(posedge ram_clk) begin
        if (mem_we_c) begin
            for (int k = 0; k < int'(LANES); k++) begin
                if (lane_q[k]) mem[maddr_c][k*NIB_W +: NIB_W] <= wdata_q[k*NIB_W +: NIB_W];
            end
        end
        if (state_q == ST_ACC) rd_q <= mem[maddr_c];
    end
endmodule

// File: tb/tb_ram_paged_ctl.sv
// Directed bench for ram_paged_ctl: a transaction-level model predicts every response,
// pa and cmd_ready cycle by cycle; literal expectations pin the model on the key cases.
module tb_ram_paged_ctl;
    logic        ram_clk = 1'b0;
    logic        ram_rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_va;
    logic [1:0]  cmd_lane;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_fault;
    logic [16:0] pa;

    always #5 ram_clk = ~ram_clk;

    ram_paged_ctl dut (
        .ram_clk(ram_clk), .ram_rst(ram_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_va(cmd_va), .cmd_lane(cmd_lane), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_fault(rsp_fault), .pa(pa)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit chk_en = 0;

    always @(posedge ram_clk) cyc <= cyc + 1;

    // Model state: page table, sparse memory, expected outputs and deferred side effects
    logic [3:0]  m_ppn [4];
    logic        m_wp [4];
    logic [7:0]  m_mem [int];
    logic [16:0] pa_old, pa_new;
    int          pa_cyc, ready_cyc, resp_cyc;
    logic [7:0]  e_data;
    logic        e_fault;
    bit          e_known;
    bit          p_wr, p_ld;
    int          p_addr, p_idx;
    logic [7:0]  p_data;
    logic [1:0]  p_lane;
    logic [3:0]  p_ppn;
    logic        p_wp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_identity();
        for (int i = 0; i < 4; i++) begin
            m_ppn[i] = 4'(i);
            m_wp[i]  = 1'b0;
        end
    endtask

    task automatic model_accept(input logic [1:0] op, input int va, input logic [1:0] lane,
                                input logic [7:0] wd, input int acc);
        int idx, pi, p;
        bit rf, wf;
        idx = (va >> 13) % 4;
        pi  = va % 4;
        p   = int'(m_ppn[idx]) * 8192 + (va % 8192);
        rf  = p >= 16384;
        wf  = (op == 2'b01) && m_wp[idx];
        pa_old = (acc >= pa_cyc) ? pa_new : pa_old;
        pa_new = 17'(p);
        pa_cyc = acc + 1;
        resp_cyc  = acc + (op[1] ? 2 : 3);
        ready_cyc = resp_cyc;
        p_wr = 0; p_ld = 0; e_known = 1; e_fault = 0; e_data = 8'h00;
        case (op)
            2'b00: begin
                e_fault = rf;
                if (!rf) begin
                    if (m_mem.exists(p)) e_data = m_mem[p];
                    else e_known = 0;
                end
            end
            2'b01: begin
                e_fault = rf | wf;
                if (!(rf | wf)) begin
                    p_wr = 1; p_addr = p; p_data = wd; p_lane = lane;
                end
            end
            2'b10: begin
                p_ld = 1; p_idx = pi; p_ppn = wd[3:0]; p_wp = wd[4];
            end
            default: e_data = {3'b000, m_wp[pi], m_ppn[pi]};
        endcase
    endtask

    task automatic model_commit();
        logic [7:0] v;
        if (p_wr) begin
            if (p_lane == 2'b11) m_mem[p_addr] = p_data;
            else if (m_mem.exists(p_addr)) begin
                v = m_mem[p_addr];
                for (int k = 0; k < 2; k++) if (p_lane[k]) v[k*4 +: 4] = p_data[k*4 +: 4];
                m_mem[p_addr] = v;
            end
        end
        if (p_ld) begin
            m_ppn[p_idx] = p_ppn;
            m_wp[p_idx]  = p_wp;
        end
        p_wr = 0; p_ld = 0;
    endtask

    // Called in the cycle where ram_rst is raised; effects land on the next edge.
    task automatic model_reset();
        pa_old = (cyc >= pa_cyc) ? pa_new : pa_old;
        pa_new = 17'h0;
        pa_cyc = cyc + 1;
        resp_cyc = -1;
        ready_cyc = cyc + 1;
        p_wr = 0; p_ld = 0;
        model_identity();
    endtask

    // Per-cycle comparison against the model
    initial begin
        logic [16:0] pe;
        forever begin
            @(negedge ram_clk); #1;
            if (chk_en) begin
                pe = (cyc >= pa_cyc) ? pa_new : pa_old;
                chk("cmd_ready", 32'(cmd_ready), 32'(!ram_rst && cyc >= ready_cyc));
                chk("rsp_valid", 32'(rsp_valid), 32'(cyc == resp_cyc));
                chk("pa", 32'(pa), 32'(pe));
                if (cyc == resp_cyc) begin
                    chk("rsp_fault", 32'(rsp_fault), 32'(e_fault));
                    if (e_known) chk("rsp_data", 32'(rsp_data), 32'(e_data));
                end
            end
        end
    end

    task automatic run_cmd(input logic [1:0] op, input logic [15:0] va, input logic [1:0] lane,
                           input logic [7:0] wd, output logic [7:0] d, output logic f,
                           output int lat);
        int n, acc;
        n = 0; d = 8'hxx; f = 1'bx; lat = -1;
        while (!cmd_ready && n < 20) begin
            @(negedge ram_clk); #1;
            n++;
        end
        if (!cmd_ready) begin
            checks++; failures++;
            $display("FAIL accept_timeout: cmd_ready got 0 expected 1 (cycle %0d)", cyc);
            return;
        end
        cmd_valid = 1'b1; cmd_op = op; cmd_va = va; cmd_lane = lane; cmd_wdata = wd;
        @(posedge ram_clk); #1;
        acc = cyc;
        model_accept(op, int'(va), lane, wd, acc);
        cmd_valid = 1'b0;
        cmd_op = 2'($urandom); cmd_va = 16'($urandom);
        cmd_lane = 2'($urandom); cmd_wdata = 8'($urandom);
        for (int i = 0; i < 8 && lat < 0; i++) begin
            @(negedge ram_clk); #1;
            if (rsp_valid) begin
                lat = cyc - acc; d = rsp_data; f = rsp_fault;
            end
        end
        if (lat < 0) begin
            checks++; failures++;
            $display("FAIL rsp_timeout: rsp_valid got 0 expected 1 within 8 cycles");
        end
        model_commit();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation got stuck expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        logic       f;
        int         lat, acc;
        ram_rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_va = '0; cmd_lane = '0; cmd_wdata = '0;
        model_identity();
        pa_old = '0; pa_new = '0; pa_cyc = 0; ready_cyc = 0; resp_cyc = -1;
        p_wr = 0; p_ld = 0; e_known = 0; e_data = '0; e_fault = 0;
        repeat (2) @(posedge ram_clk);
        @(negedge ram_clk); #1;
        chk_en = 1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data",  32'(rsp_data),  32'd0);
        chk("rst_rsp_fault", 32'(rsp_fault), 32'd0);
        chk("rst_pa",        32'(pa),        32'd0);
        @(negedge ram_clk);
        ram_rst = 1'b0;
        #2;
        chk("ready_after_rst", 32'(cmd_ready), 32'd1);

        run_cmd(2'b11, 16'h0002, 2'b00, 8'h00, d, f, lat);
        chk("pread2_data", 32'(d), 32'h02);
        chk("pread2_fault", 32'(f), 32'd0);
        chk("pread_lat", 32'(lat), 32'd2);

        run_cmd(2'b01, 16'h0123, 2'b11, 8'hA5, d, f, lat);
        chk("wr_fault", 32'(f), 32'd0);
        chk("wr_lat", 32'(lat), 32'd3);
        run_cmd(2'b00, 16'h0123, 2'b00, 8'h00, d, f, lat);
        chk("rd_a5", 32'(d), 32'hA5);
        chk("rd_lat", 32'(lat), 32'd3);
        chk("pa_0123", 32'(pa), 32'h00123);

        run_cmd(2'b01, 16'h0123, 2'b01, 8'h3C, d, f, lat);
        run_cmd(2'b00, 16'h0123, 2'b00, 8'h00, d, f, lat);
        chk("rd_lane_mask", 32'(d), 32'hAC);

        run_cmd(2'b01, 16'h2010, 2'b11, 8'h5A, d, f, lat);
        run_cmd(2'b10, 16'h0000, 2'b00, 8'h11, d, f, lat);
        chk("pload_data", 32'(d), 32'h00);
        run_cmd(2'b01, 16'h0010, 2'b11, 8'h77, d, f, lat);
        chk("wp_fault", 32'(f), 32'd1);
        run_cmd(2'b00, 16'h0010, 2'b00, 8'h00, d, f, lat);
        chk("remap_rd_data", 32'(d), 32'h5A);
        chk("remap_rd_fault", 32'(f), 32'd0);
        chk("pa_02010", 32'(pa), 32'h02010);

        run_cmd(2'b10, 16'h0001, 2'b00, 8'h0F, d, f, lat);
        run_cmd(2'b00, 16'h2000, 2'b00, 8'h00, d, f, lat);
        chk("range_fault", 32'(f), 32'd1);
        chk("range_data", 32'(d), 32'h00);
        chk("pa_1e000", 32'(pa), 32'h1E000);

        // Restore page 0 and protect page 2, then reset during a write's ACC cycle
        run_cmd(2'b10, 16'h0000, 2'b00, 8'h00, d, f, lat);
        run_cmd(2'b10, 16'h0002, 2'b00, 8'h15, d, f, lat);
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_va = 16'h0123; cmd_lane = 2'b11; cmd_wdata = 8'h99;
        @(posedge ram_clk); #1;
        acc = cyc;
        model_accept(2'b01, 32'h0123, 2'b11, 8'h99, acc);
        cmd_valid = 1'b0;
        @(negedge ram_clk);
        @(negedge ram_clk);
        ram_rst = 1'b1;
        model_reset();
        repeat (2) @(negedge ram_clk);
        ram_rst = 1'b0;
        #2;
        run_cmd(2'b00, 16'h0123, 2'b00, 8'h00, d, f, lat);
        chk("rst_no_write", 32'(d), 32'hAC);
        run_cmd(2'b11, 16'h0001, 2'b00, 8'h00, d, f, lat);
        chk("rst_ident_p1", 32'(d), 32'h01);
        run_cmd(2'b11, 16'h0002, 2'b00, 8'h00, d, f, lat);
        chk("rst_ident_p2", 32'(d), 32'h02);

        repeat (3) @(negedge ram_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
